// File: rtl/uart_tx_cfg_if.sv
// Upstream word handshake plus serial-line status for uart_tx_cfg.
// The DUT uses the slave modport; the word source uses master.
interface uart_tx_cfg_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] din;
  logic                 din_valid;
  logic                 din_ready;
  logic                 tx;
  logic                 tx_done;
  logic                 busy;

  modport master (
    output din, din_valid,
    input  din_ready, tx, tx_done, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, tx, tx_done, busy
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, LSB-first data, optional parity,
// one or two stop bits, each bit exactly CLK_DIV clocks long.
module uart_tx_cfg #(
  parameter int unsigned CLK_DIV   = 868,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_cfg_if.slave  bus
);

  localparam int unsigned BaudW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BitW  = $clog2(DATA_BITS + 1);

  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLK_DIV - 1);
  localparam logic [BitW-1:0]  DataLast = BitW'(DATA_BITS - 1);
  localparam logic [BitW-1:0]  StopLast = BitW'(STOP_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e               state_q, state_d;
  logic [BaudW-1:0]     baud_q, baud_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 tx_done_q, tx_done_d;
  logic                 accept;
  logic                 bit_end;

  assign bus.din_ready = (state_q == StIdle) & ~rst;
  assign bus.busy      = (state_q != StIdle);
  assign bus.tx        = tx_q;
  assign bus.tx_done   = tx_done_q;

  assign accept  = bus.din_valid & bus.din_ready;
  assign bit_end = (baud_q == BaudLast);

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    tx_done_d = 1'b0;

    if (state_q != StIdle) begin
      baud_d = bit_end ? '0 : baud_q + BaudW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StStart;
          shreg_d = bus.din;
          // Odd parity inverts the XOR so the total count of ones is odd.
          par_d   = (PARITY == 1) ? ~^bus.din : ^bus.din;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          bit_d   = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == DataLast) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? StParity : StStop;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          bit_d   = '0;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (bit_q == StopLast) begin
            state_d   = StIdle;
            bit_d     = '0;
            tx_done_d = 1'b1;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // tx is registered, so it is derived from the state being entered.
    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shreg_d[0];
      StParity: tx_d = par_q;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      tx_done_q <= tx_done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: four instances cover 8N1, even parity,
// odd parity with two stop bits, and a 5-bit frame at full baud divisor.
module tb_uart_tx_cfg;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  uart_tx_cfg_if #(.DATA_BITS(8)) if0 ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if1 ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if2 ();
  uart_tx_cfg_if #(.DATA_BITS(5)) if3 ();

  uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .bus(if0.slave));
  uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_even (
    .clk(clk), .rst(rst), .bus(if1.slave));
  uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u_odd2 (
    .clk(clk), .rst(rst), .bus(if2.slave));
  uart_tx_cfg #(.CLK_DIV(868), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1)) u_5bit (
    .clk(clk), .rst(rst), .bus(if3.slave));

  logic [3:0] tx_v, done_v, busy_v, rdy_v;
  assign tx_v   = {if3.tx, if2.tx, if1.tx, if0.tx};
  assign done_v = {if3.tx_done, if2.tx_done, if1.tx_done, if0.tx_done};
  assign busy_v = {if3.busy, if2.busy, if1.busy, if0.busy};
  assign rdy_v  = {if3.din_ready, if2.din_ready, if1.din_ready, if0.din_ready};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int d, input logic v, input logic [8:0] w);
    case (d)
      0: begin if0.din_valid = v; if0.din = w[7:0]; end
      1: begin if1.din_valid = v; if1.din = w[7:0]; end
      2: begin if2.din_valid = v; if2.din = w[7:0]; end
      default: begin if3.din_valid = v; if3.din = w[4:0]; end
    endcase
  endtask

  // Offers a word and returns #1 after the accepting edge with valid dropped.
  task automatic send_word(input int d, input logic [8:0] w);
    bit ok;
    ok = 1'b0;
    set_in(d, 1'b1, w);
    for (int i = 0; i < 20 && !ok; i++) begin
      if (rdy_v[d] === 1'b1) ok = 1'b1;
      tick();
    end
    set_in(d, 1'b0, w);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL accept_timeout dut=%0d: din_ready never seen, required 1 within 20 cycles", d);
    end
  endtask

  task automatic test_reset();
    set_in(0, 1'b1, 9'h0FF);
    repeat (3) tick();
    n_cmp++;
    if (tx_v !== 4'hF || done_v !== 4'h0 || busy_v !== 4'h0 || rdy_v !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_state: tx=%b done=%b busy=%b ready=%b, required 1111 0000 0000 0000",
               tx_v, done_v, busy_v, rdy_v);
    end
    set_in(0, 1'b0, 9'h000);
    rst = 1'b0;
    tick();
    n_cmp++;
    if (rdy_v !== 4'hF || busy_v !== 4'h0 || tx_v !== 4'hF) begin
      n_fail++;
      $display("FAIL after_reset: ready=%b busy=%b tx=%b, required 1111 0000 1111",
               rdy_v, busy_v, tx_v);
    end
  endtask

  task automatic test_8n1();
    logic [9:0] exp;
    exp = {1'b1, 8'h8A, 1'b0};
    send_word(0, 9'h08A);
    for (int k = 0; k < 40; k++) begin
      n_cmp++;
      if (tx_v[0] !== exp[k/4] || done_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL 8n1_line k=%0d: tx=%b done=%b busy=%b, required tx=%b done=0 busy=1",
                 k, tx_v[0], done_v[0], busy_v[0], exp[k/4]);
      end
      tick();
    end
    n_cmp++;
    if (done_v[0] !== 1'b1 || tx_v[0] !== 1'b1 || rdy_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL 8n1_done: done=%b tx=%b ready=%b busy=%b, required 1 1 1 0",
               done_v[0], tx_v[0], rdy_v[0], busy_v[0]);
    end
    tick();
    n_cmp++;
    if (done_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL 8n1_done_width: done=%b, required 0", done_v[0]);
    end
  endtask

  task automatic test_even_parity();
    logic [10:0] exp;
    exp = {1'b1, 1'b1, 8'h8A, 1'b0};
    send_word(1, 9'h08A);
    for (int k = 0; k < 44; k++) begin
      n_cmp++;
      if (tx_v[1] !== exp[k/4] || done_v[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL even_line k=%0d: tx=%b done=%b, required tx=%b done=0",
                 k, tx_v[1], done_v[1], exp[k/4]);
      end
      tick();
    end
    n_cmp++;
    if (done_v[1] !== 1'b1 || tx_v[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL even_done: done=%b tx=%b, required 1 1", done_v[1], tx_v[1]);
    end
    tick();
  endtask

  task automatic test_odd_two_stop();
    logic [11:0] exp;
    exp = {2'b11, 1'b0, 8'h8A, 1'b0};
    send_word(2, 9'h08A);
    for (int k = 0; k < 48; k++) begin
      n_cmp++;
      if (tx_v[2] !== exp[k/4] || done_v[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL odd2_line k=%0d: tx=%b done=%b, required tx=%b done=0",
                 k, tx_v[2], done_v[2], exp[k/4]);
      end
      tick();
    end
    n_cmp++;
    if (done_v[2] !== 1'b1 || tx_v[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL odd2_done: done=%b tx=%b, required 1 1", done_v[2], tx_v[2]);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [9:0] e55, eaa;
    logic       etx, edone, ebusy;
    e55 = {1'b1, 8'h55, 1'b0};
    eaa = {1'b1, 8'hAA, 1'b0};
    set_in(0, 1'b1, 9'h055);
    tick();
    set_in(0, 1'b1, 9'h0AA);
    for (int k = 0; k < 82; k++) begin
      if (k < 40) begin
        etx = e55[k/4]; edone = 1'b0; ebusy = 1'b1;
      end else if (k == 40 || k == 81) begin
        etx = 1'b1; edone = 1'b1; ebusy = 1'b0;
      end else begin
        etx = eaa[(k-41)/4]; edone = 1'b0; ebusy = 1'b1;
      end
      n_cmp++;
      if (tx_v[0] !== etx || done_v[0] !== edone || busy_v[0] !== ebusy ||
          rdy_v[0] !== ~ebusy) begin
        n_fail++;
        $display("FAIL b2b_line k=%0d: tx=%b done=%b busy=%b ready=%b, required %b %b %b %b",
                 k, tx_v[0], done_v[0], busy_v[0], rdy_v[0], etx, edone, ebusy, ~ebusy);
      end
      if (k == 41) set_in(0, 1'b0, 9'h000);
      tick();
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] exp;
    send_word(0, 9'h08A);
    repeat (15) tick();
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || rdy_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_abort: tx=%b busy=%b done=%b ready=%b, required 1 0 0 0",
               tx_v[0], busy_v[0], done_v[0], rdy_v[0]);
    end
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 50; k++) begin
      n_cmp++;
      if (done_v[0] !== 1'b0 || tx_v[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL midrst_quiet k=%0d: done=%b tx=%b, required 0 1", k, done_v[0], tx_v[0]);
      end
      tick();
    end
    exp = {1'b1, 8'h3C, 1'b0};
    send_word(0, 9'h03C);
    for (int k = 0; k < 40; k++) begin
      n_cmp++;
      if (tx_v[0] !== exp[k/4] || done_v[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_next k=%0d: tx=%b done=%b, required tx=%b done=0",
                 k, tx_v[0], done_v[0], exp[k/4]);
      end
      tick();
    end
    n_cmp++;
    if (done_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_next_done: done=%b, required 1", done_v[0]);
    end
    tick();
  endtask

  task automatic test_five_bit();
    logic [6:0] exp;
    exp = {1'b1, 5'h13, 1'b0};
    send_word(3, 9'h013);
    for (int k = 0; k < 7 * 868; k++) begin
      n_cmp++;
      if (tx_v[3] !== exp[k/868] || done_v[3] !== 1'b0) begin
        n_fail++;
        $display("FAIL five_line k=%0d: tx=%b done=%b, required tx=%b done=0",
                 k, tx_v[3], done_v[3], exp[k/868]);
      end
      tick();
    end
    n_cmp++;
    if (done_v[3] !== 1'b1 || tx_v[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL five_done: done=%b tx=%b, required 1 1", done_v[3], tx_v[3]);
    end
    tick();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    for (int d = 0; d < 4; d++) set_in(d, 1'b0, 9'h000);
    #1;
    test_reset();
    test_8n1();
    test_even_parity();
    test_odd_two_stop();
    test_back_to_back();
    test_reset_mid_frame();
    test_five_bit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
